// File: rtl/snitch_pkg.sv
// Shared cluster types plus the constants and event enumeration used by the
// performance counter peripheral.
package snitch_pkg;

    localparam int unsigned IdWidth = 4;

    localparam logic [31:0] PerfCounterBase   = 32'h4001_0000;
    localparam int unsigned PerfCounterStride = 8;
    localparam logic [31:0] PerfCtrlOffset    = 32'hF000;
    localparam int unsigned NrPerfEvents      = 4;

    typedef enum logic [1:0] {
        RetiredInsts   = 2'd0,
        IssueCoreToFpu = 2'd1,
        IssueFpuSeq    = 2'd2,
        IssueFpu       = 2'd3
    } perf_event_e;

    typedef struct packed {
        logic retired_insts;
        logic issue_core_to_fpu;
        logic issue_fpu_seq;
        logic issue_fpu;
    } core_events_t;

    typedef struct packed {
        logic [31:0]        addr;
        logic [IdWidth-1:0] id;
        logic [3:0]         amo;
        logic               write;
        logic [31:0]        data;
        logic [3:0]         strb;
    } dreq_t;

    typedef struct packed {
        logic [31:0]        data;
        logic [IdWidth-1:0] id;
        logic               write;
        logic               error;
    } dresp_t;

    // Flattens one core's strobes so that bit position equals perf_event_e.
    function automatic logic [NrPerfEvents-1:0] event_vector(input core_events_t ev);
        logic [NrPerfEvents-1:0] v;
        v                 = '0;
        v[RetiredInsts]   = ev.retired_insts;
        v[IssueCoreToFpu] = ev.issue_core_to_fpu;
        v[IssueFpuSeq]    = ev.issue_fpu_seq;
        v[IssueFpu]       = ev.issue_fpu;
        return v;
    endfunction

endpackage

// File: rtl/snitch_perf_counter.sv
// Single 32-bit event counter with a byte-masked write port; a write in the
// same cycle as an increment wins and the increment is dropped.
module snitch_perf_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic [31:0] value
);

    logic [31:0] value_reg;
    logic [31:0] value_next;
    logic [31:0] wr_merged;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign wr_merged[gi*8 +: 8] = wr_strb[gi] ? wr_data[gi*8 +: 8] : value_reg[gi*8 +: 8];
    end

    always_comb begin
        value_next = value_reg;
        if (wr_en) begin
            value_next = wr_merged;
        end else if (inc) begin
            value_next = value_reg + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/snitch_perf_counters.sv
// Memory-mapped per-core event counters with an enable register and a
// one-entry registered response buffer.
module snitch_perf_counters
    import snitch_pkg::*;
#(
    parameter int unsigned NrCores  = 4,
    parameter logic [31:0] BaseAddr = PerfCounterBase
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  core_events_t [NrCores-1:0] core_events_i,
    input  dreq_t                      req_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    output dresp_t                     resp_o,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i
);

    localparam int unsigned NumCounters = NrCores * NrPerfEvents;

    logic [31:0] offset;
    logic [28:0] ctr_idx;
    logic        ctr_hit;
    logic        ctrl_hit;
    logic        req_ok;
    logic        accept;
    logic        wr_accept;

    logic                   enable_reg;
    logic [NumCounters-1:0] event_flat;
    logic [31:0]            counter_value [NumCounters];
    logic [31:0]            rd_data;

    dresp_t resp_reg;
    dresp_t resp_next;
    logic   resp_valid_reg;

    // Offset wraps as unsigned, so addresses below BaseAddr land far out of range.
    assign offset    = req_i.addr - BaseAddr;
    assign ctr_idx   = offset[31:3];
    assign ctr_hit   = (offset[2:0] == 3'b000) && (ctr_idx < 29'(NumCounters));
    assign ctrl_hit  = (offset == PerfCtrlOffset);
    assign req_ok    = (req_i.amo == 4'd0) && (ctr_hit || ctrl_hit);

    assign req_ready_o = !resp_valid_reg || resp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign wr_accept   = accept && req_ok && req_i.write;

    for (genvar gi = 0; gi < NrCores; gi++) begin : g_core_events
        assign event_flat[gi*NrPerfEvents +: NrPerfEvents] = event_vector(core_events_i[gi]);
    end

    for (genvar gi = 0; gi < NumCounters; gi++) begin : g_counter
        snitch_perf_counter i_counter (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .inc     (enable_reg && event_flat[gi]),
            .wr_en   (wr_accept && ctr_hit && (ctr_idx == 29'(gi))),
            .wr_data (req_i.data),
            .wr_strb (req_i.strb),
            .value   (counter_value[gi])
        );
    end

    always_comb begin
        rd_data = '0;
        if (ctrl_hit) begin
            rd_data = {31'd0, enable_reg};
        end
        for (int k = 0; k < NumCounters; k++) begin
            if (ctr_hit && (ctr_idx == 29'(k))) begin
                rd_data = counter_value[k];
            end
        end
    end

    always_comb begin
        resp_next       = '0;
        resp_next.id    = req_i.id;
        resp_next.write = req_i.write;
        resp_next.error = !req_ok;
        if (req_ok && !req_i.write) begin
            resp_next.data = rd_data;
        end
    end

    // The old enable gates this cycle's increments, so a disabling write still counts its own cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_reg <= 1'b1;
        end else if (wr_accept && ctrl_hit && req_i.strb[0]) begin
            enable_reg <= req_i.data[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_reg <= 1'b0;
            resp_reg       <= '0;
        end else if (accept) begin
            resp_valid_reg <= 1'b1;
            resp_reg       <= resp_next;
        end else if (resp_ready_i) begin
            resp_valid_reg <= 1'b0;
        end
    end

    assign resp_o       = resp_reg;
    assign resp_valid_o = resp_valid_reg;

endmodule

// File: tb/tb_snitch_perf_counters.sv
// Directed and randomized bench for snitch_perf_counters against an
// array-based reference model of counters, enable and response buffer.
module tb_snitch_perf_counters;
    import snitch_pkg::*;

    localparam int          NrCores = 4;
    localparam int          NC      = NrCores * 4;
    localparam logic [31:0] Base    = 32'h4001_0000;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    core_events_t [NrCores-1:0] core_events;
    dreq_t                      req;
    logic                       req_valid;
    logic                       req_ready;
    dresp_t                     resp;
    logic                       resp_valid;
    logic                       resp_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_ctr [NC];
    logic        m_en;
    logic        m_valid;
    dresp_t      m_resp;

    snitch_perf_counters #(
        .NrCores  (NrCores),
        .BaseAddr (Base)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .core_events_i (core_events),
        .req_i         (req),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .resp_o        (resp),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) m_ctr[k] = '0;
        m_en    = 1'b1;
        m_valid = 1'b0;
        m_resp  = '0;
    endtask

    task automatic set_events(input logic [15:0] ev);
        for (int c = 0; c < NrCores; c++) begin
            core_events[c].retired_insts     = ev[c*4+0];
            core_events[c].issue_core_to_fpu = ev[c*4+1];
            core_events[c].issue_fpu_seq     = ev[c*4+2];
            core_events[c].issue_fpu         = ev[c*4+3];
        end
    endtask

    // One clock cycle: drive inputs, predict, advance, compare. Entered at posedge+1.
    task automatic cyc(input logic [15:0] ev, input logic v, input logic [31:0] addr,
                       input logic [3:0] id, input logic wr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [3:0] amo);
        logic        acc;
        logic        ok;
        logic [31:0] off;
        int          idx;
        dresp_t      nr;
        set_events(ev);
        req_valid = v;
        req.addr  = addr;
        req.id    = id;
        req.write = wr;
        req.data  = data;
        req.strb  = strb;
        req.amo   = amo;
        @(negedge clk);
        check("req_ready", req_ready, !m_valid || resp_ready);
        acc = v && (!m_valid || resp_ready);
        off = addr - Base;
        ok  = (amo == 4'd0) && (off % 8 == 0) && ((off / 8 < NC) || (off == 32'hF000));
        idx = (off / 8 < NC) ? int'(off / 8) : -1;
        nr       = '0;
        nr.id    = id;
        nr.write = wr;
        nr.error = !ok;
        if (ok && !wr) nr.data = (off == 32'hF000) ? {31'd0, m_en} : m_ctr[idx];
        @(posedge clk);
        for (int k = 0; k < NC; k++) begin
            if (acc && ok && wr && off != 32'hF000 && idx == k) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) m_ctr[k][8*b +: 8] = data[8*b +: 8];
            end else if (m_en && ev[k]) begin
                m_ctr[k] = m_ctr[k] + 32'd1;
            end
        end
        if (acc && ok && wr && off == 32'hF000 && strb[0]) m_en = data[0];
        if (acc) begin
            m_valid = 1'b1;
            m_resp  = nr;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("resp_valid", resp_valid, m_valid);
        if (m_valid) check("resp", resp, m_resp);
    endtask

    task automatic rd(input int k, input logic [3:0] id);
        cyc(16'h0, 1'b1, Base + 32'(8*k), id, 1'b0, 32'h0, 4'h0, 4'h0);
    endtask

    task automatic wrr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input logic [15:0] ev);
        cyc(ev, 1'b1, addr, 4'h0, 1'b1, data, strb, 4'h0);
    endtask

    task automatic idle(input logic [15:0] ev);
        cyc(ev, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 4'h0);
    endtask

    task automatic read_all();
        for (int k = 0; k < NC; k++) rd(k, 4'(k));
    endtask

    initial begin
        logic [31:0] snap;
        dresp_t      held;
        logic [31:0] a;
        int          sel;

        model_reset();
        set_events(16'h0);
        req        = '0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        #12;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp", resp, '0);
        check("rst_req_ready", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Core 1 retired_insts x5, then read k=4 with id 3.
        repeat (5) idle(16'h0010);
        cyc(16'h0, 1'b1, Base + 32'h20, 4'd3, 1'b0, 32'h0, 4'h0, 4'h0);
        check("t1_data", resp.data, 32'd5);
        check("t1_id", resp.id, 4'd3);
        check("t1_error", resp.error, 1'b0);

        // Wrap of counter 0.
        wrr(Base, 32'hFFFF_FFFE, 4'hF, 16'h0);
        repeat (3) idle(16'h0001);
        rd(0, 4'd1);
        check("wrap_data", resp.data, 32'h1);

        // Write beats a same-cycle event; then a partial write.
        wrr(Base + 32'h18, 32'h10, 4'hF, 16'h0008);
        rd(3, 4'd2);
        check("wr_wins", resp.data, 32'h10);
        wrr(Base + 32'h18, 32'h0000_AB00, 4'b0010, 16'h0);
        rd(3, 4'd2);
        check("partial_wr", resp.data, 32'h0000_AB10);

        // Disable, flood with events, re-enable.
        wrr(Base + 32'hF000, 32'h0, 4'hF, 16'hFFFF);
        repeat (10) idle(16'hFFFF);
        read_all();
        rd(4, 4'd0);
        snap = resp.data;
        wrr(Base + 32'hF000, 32'h1, 4'hF, 16'hFFFF);
        idle(16'h0010);
        rd(4, 4'd0);
        check("resume", resp.data, snap + 32'd1);

        // Error accesses leave state untouched.
        cyc(16'h0, 1'b1, Base + 32'h4, 4'd5, 1'b0, 32'h0, 4'h0, 4'h0);
        check("misalign_err", resp.error, 1'b1);
        check("misalign_data", resp.data, 32'h0);
        cyc(16'h0, 1'b1, Base + 32'(8*NC), 4'd6, 1'b1, 32'h1234, 4'hF, 4'h0);
        check("range_err", resp.error, 1'b1);
        cyc(16'h0, 1'b1, Base, 4'd7, 1'b1, 32'h5555, 4'hF, 4'h1);
        check("amo_err", resp.error, 1'b1);
        check("amo_data", resp.data, 32'h0);
        read_all();

        // Back-pressure: response held, no acceptance, then streaming.
        resp_ready = 1'b0;
        rd(0, 4'd1);
        held = resp;
        repeat (4) begin
            rd(1, 4'd2);
            check("stall_hold", resp, held);
        end
        resp_ready = 1'b1;
        rd(1, 4'd2);
        check("stream_id0", resp.id, 4'd2);
        rd(2, 4'd3);
        check("stream_id1", resp.id, 4'd3);
        rd(3, 4'd4);
        check("stream_id2", resp.id, 4'd4);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                6:       a = Base + 32'hF000;
                7:       a = Base + 32'(8 * $urandom_range(0, NC-1)) + 32'($urandom_range(1, 7));
                8:       a = Base + 32'(8 * (NC + $urandom_range(0, 50)));
                9:       a = $urandom;
                default: a = Base + 32'(8 * $urandom_range(0, NC-1));
            endcase
            resp_ready = ($urandom_range(0, 3) != 0);
            cyc(16'($urandom), ($urandom_range(0, 2) != 0), a, 4'($urandom), 1'($urandom),
                (sel == 6) ? 32'($urandom_range(0, 1)) : $urandom, 4'($urandom),
                ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
        end
        resp_ready = 1'b1;
        read_all();

        // Reset during a pending response drops it.
        resp_ready = 1'b0;
        rd(5, 4'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", resp_valid, 1'b0);
        check("midrst_resp", resp, '0);
        model_reset();
        resp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(5, 4'd9);
        check("post_rst_data", resp.data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snitch_perf_counters.md
# snitch_perf_counters

Cluster-peripheral block that counts the per-core `core_events_t` strobes and exposes the counters as memory-mapped registers at `PerfCounterBase` (0x4001_0000). It consumes the event strobes the cores produce and serves `dreq_t`/`dresp_t` requests forwarded by the cluster peripheral decoder. Each access gets a single-cycle registered response.

## Interface
- `NrCores`, default 4: number of cores; counter count is `NrCores*4`.
- `BaseAddr`, default `snitch_pkg::PerfCounterBase`: base address of the counter window.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `core_events_i`  in  `NrCores` x `core_events_t`  per-core event strobes. Each bit is one event in that cycle.
- `req_i`  in  `dreq_t`  request: addr, id, amo, write, data, strb.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when valid && ready.
- `resp_o`  out  `dresp_t`  response: data, id, write, error.
- `resp_valid_o`  out  1  response valid.
- `resp_ready_i`  in  1  response consumed when valid && ready.

## Operation
- Counter map:
  - Counter k = core*4 + ev.
  - ev 0 = retired_insts, 1 = issue_core_to_fpu, 2 = issue_fpu_seq, 3 = issue_fpu.
  - Counter k sits at `BaseAddr + 8*k`, with 8-byte stride.
- Control register at `BaseAddr + 0xF000`:
  - bit0 = enable, reset value 1.
  - Other bits read 0 and ignore writes.
- Counters are 32-bit and reset to 0.
- Counting:
  - When enable=1 and a strobe bit is set, the counter increments by 1.
  - A counter at 0xFFFF_FFFF wraps to 0, with no sticky flag.
- Address decode:
  - offset = addr − BaseAddr, compared as a 32-bit unsigned value.
  - A hit requires offset[2:0]=0 and (offset/8 < NrCores*4, or offset = 0xF000).
  - Any other address, or amo ≠ 0, gives error=1, data=0 and no state change.
- Read: returns the counter value before any increment in the acceptance cycle.
- Write:
  - Byte-wise update under strb. Bytes whose strb bit is 0 keep their old value.
  - If a write and an event hit the same counter in the same cycle, the write wins and the event is dropped.
  - Response data on a write is 0.
- Every response echoes the request's id and write fields.

## Timing
- Accepting a request in cycle N puts the response on `resp_o` with `resp_valid_o`=1 in cycle N+1.
- One-entry response buffer:
  - `req_ready_o` = !resp_valid_o || resp_ready_i. Back-to-back requests sustain 1 per cycle.
  - While resp_valid_o=1 and resp_ready_i=0, `resp_o` is held stable and no new request is accepted.
- Write side effects land at the clock edge that accepts the request, so a read in cycle N+1 sees the written value.
- Disabling via the control register takes effect for events starting in cycle N+1. Events in the write cycle N still count.
- Reset values:
  - resp_valid_o=0, resp_o='0.
  - req_ready_o=1 (combinational from the reset state).
  - All counters 0, enable=1.
- Asserting reset mid-transaction drops any pending response.
- No combinational path from req_i to resp_o.

## Structure
- Additions to snitch_pkg:
  - `perf_event_e` enum (RetiredInsts=0, IssueCoreToFpu=1, IssueFpuSeq=2, IssueFpu=3).
  - `PerfCounterStride` = 8.
  - `PerfCtrlOffset` = 32'hF000.
- Sub-module `snitch_perf_counter`, one per counter. It holds a 32-bit register with inputs inc, wr_en, wr_data, wr_strb, and wr has priority over inc.
- The top level contains the decode, the one-entry response register, the enable register and the counter array generate loop.

## Test plan
- Reset, then core 1 pulses retired_insts 5 times, then read addr 0x4001_0020 (k=4) with id=3 → data=5, id=3, error=0, arriving 1 cycle after acceptance.
- Write 0xFFFF_FFFE to k=0 with strb=4'hF, then 3 retired_insts strobes on core 0 → read returns 0x0000_0001 (wrap).
- In the same cycle, write 0x10 to k=3 and core 0 issue_fpu=1 → read returns 0x10. A partial write with strb=4'b0010 and data 0x0000_AB00 then gives 0x0000_AB10.
- Write 0 to 0x4001_F000, then 10 cycles of all strobes high → every counter stays unchanged. Writing 1 resumes counting from the next cycle.
- Read 0x4001_0004 (misaligned), read 0x4001_0000 + 8*NrCores*4 (out of range), and an amo=1 access → error=1, data=0, no counter changed.
- Hold resp_ready_i=0 for 4 cycles with req_valid_i=1 → req_ready_o=0 and resp_o stable. Release it → back-to-back responses at 1 per cycle with ids in order.
